// File: rtl/add_pkg.sv
// Shared constants and elaboration-time parameter check for the pipelined adder.
package add_pkg;

  localparam logic ADD_MODE = 1'b0;
  localparam logic SUB_MODE = 1'b1;

  function automatic bit params_ok(input int unsigned width, input int unsigned chunk);
    return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// CHUNK-wide ripple-carry chain of full adders; also exposes the carry into its MSB.
module add_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co   = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/add_pipe.sv
// Pipelined add/subtract: one CHUNK-bit ripple stage per register, valid/ready per stage.
module add_pipe
  import add_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  if (!params_ok(WIDTH, CHUNK)) begin : g_param_err
    $error("add_pipe: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic [STAGES-1:0] vld;
  logic [STAGES:0]   rdy;

  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      rdy[STAGES-1-i] = !vld[STAGES-1-i] || rdy[STAGES-i];
    end
  end

  assign in_ready = rdy[0];

  // Stage k holds only the operand bits above its chunk, so its operand
  // registers shrink by CHUNK per stage and the last stage has none.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int unsigned WIN = WIDTH - CHUNK * k;

    logic [WIN-1:0]   a_in;
    logic [WIN-1:0]   bn_in;
    logic             c_in;
    logic             v_in;
    logic [WIDTH-1:0] res_in;
    logic [CHUNK-1:0] sum;
    logic             cout;
    logic             cmsb;
    logic [WIDTH-1:0] res_d;

    logic             valid_q;
    logic             carry_q;
    logic [WIDTH-1:0] res_q;

    if (k == 0) begin : g_src
      assign a_in   = a;
      assign bn_in  = (sub == SUB_MODE) ? ~b  : b;
      assign c_in   = (sub == SUB_MODE) ? ~ci : ci;
      assign v_in   = in_valid;
      assign res_in = '0;
    end else begin : g_src
      assign a_in   = g_st[k-1].g_op.a_q;
      assign bn_in  = g_st[k-1].g_op.bn_q;
      assign c_in   = g_st[k-1].carry_q;
      assign v_in   = g_st[k-1].valid_q;
      assign res_in = g_st[k-1].res_q;
    end

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (a_in[CHUNK-1:0]),
      .b    (bn_in[CHUNK-1:0]),
      .ci   (c_in),
      .s    (sum),
      .co   (cout),
      .cmsb (cmsb)
    );

    assign res_d  = res_in | (WIDTH'(sum) << (CHUNK * k));
    assign vld[k] = valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        res_q   <= '0;
      end else if (rdy[k]) begin
        valid_q <= v_in;
        carry_q <= cout;
        res_q   <= res_d;
      end
    end

    if (k < STAGES - 1) begin : g_op
      logic [WIN-CHUNK-1:0] a_q;
      logic [WIN-CHUNK-1:0] bn_q;
      logic                 cmsb_unused;

      assign cmsb_unused = cmsb;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q  <= '0;
          bn_q <= '0;
        end else if (rdy[k]) begin
          a_q  <= a_in[WIN-1:CHUNK];
          bn_q <= bn_in[WIN-1:CHUNK];
        end
      end
    end else begin : g_last
      logic ovf_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (rdy[k]) begin
          ovf_q <= cmsb ^ cout;
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].valid_q;
  assign s         = g_st[STAGES-1].res_q;
  assign co        = g_st[STAGES-1].carry_q;
  assign ovf       = g_st[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe (WIDTH=16, CHUNK=4) with an arithmetic reference model.
module tb_add_pipe;

  localparam int unsigned W = 16;
  localparam int unsigned C = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ci = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         co;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  logic [17:0] q[$];
  logic        held_v = 1'b0;
  logic [17:0] held_val = '0;

  always #5 clk = ~clk;

  add_pipe #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ovf       (ovf)
  );

  // Returns {co, s, ovf} computed with plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] ta, input logic [15:0] tb_,
                                        input logic tci, input logic tsub);
    longint ua, ub, u, sa, sb, r;
    logic   tco;
    ua = longint'(ta);
    ub = longint'(tb_);
    sa = longint'($signed(ta));
    sb = longint'($signed(tb_));
    if (tsub) begin
      u   = ua - ub - longint'(tci);
      r   = sa - sb - longint'(tci);
      tco = (u >= 0);
    end else begin
      u   = ua + ub + longint'(tci);
      r   = sa + sb + longint'(tci);
      tco = (u >= 65536);
    end
    return {tco, u[15:0], (r > 32767) || (r < -32768)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: transfers are decided by signal values just before the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("stall_valid_hold", 32'(out_valid), 32'd1);
        check("stall_data_hold", 32'({co, s, ovf}), 32'(held_val));
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_output", 32'(out_valid), 32'd0);
        end else if (out_ready) begin
          check("scoreboard_result", 32'({co, s, ovf}), 32'(q[0]));
          void'(q.pop_front());
          n_out++;
        end
      end
      held_v   = out_valid && !out_ready;
      held_val = {co, s, ovf};
      if (in_valid && in_ready) q.push_back(model(a, b, ci, sub));
    end
  end

  task automatic directed(input string name, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tci, input logic tsub, input logic [17:0] lit);
    check({name, "_model"}, 32'(model(ta, tb_, tci, tsub)), 32'(lit));
    @(posedge clk); #1;
    a = ta; b = tb_; ci = tci; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 check({name, "_early"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_result"}, 32'({co, s, ovf}), 32'(lit));
    @(posedge clk);
  endtask

  initial begin
    int sent, stall, accepted, out_base;
    logic seen, low_seen, spur;

    @(posedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s", 32'(s), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2 rst = 1'b0;

    directed("ripple1", 16'h0FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 16'h1000, 1'b0});
    directed("ripple2", 16'hFFFF, 16'h0001, 1'b1, 1'b0, {1'b1, 16'h0001, 1'b0});
    directed("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 16'h8000, 1'b1});
    directed("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 16'h7FFF, 1'b1});
    directed("borrow0", 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 16'hFFFE, 1'b0});
    directed("borrow1", 16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 16'hFFFD, 1'b0});

    // Mid-stream asynchronous reset.
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h1111; ci = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_s", 32'(s), 32'h0);
    check("async_rst_co", 32'(co), 32'd0);
    check("async_rst_ovf", 32'(ovf), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    check("rst_ignores_in_valid", 32'(out_valid), 32'd0);
    #1 rst = 1'b0; in_valid = 1'b0;
    spur = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) spur = 1'b1;
    end
    check("no_stale_after_rst", 32'(spur), 32'd0);

    // Backpressure: 8 beats, out_ready low for 6 cycles after first out_valid.
    sent = 0; stall = 0; seen = 1'b0; low_seen = 1'b0; out_base = n_out;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      if (out_valid && !seen) begin
        seen  = 1'b1;
        stall = 6;
      end
      if (stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = 1'b1;
      end
      in_valid = (sent < 8);
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      #1;
      if (!in_ready) low_seen = 1'b1;
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_sent", 32'(sent), 32'd8);
    check("bp_in_ready_fell", 32'(low_seen), 32'd1);
    check("bp_all_out", 32'(n_out - out_base), 32'd8);
    check("bp_queue_empty", 32'(q.size()), 32'd0);

    // Random soak.
    accepted = 0;
    for (int cyc = 0; cyc < 20000 && accepted < 2000; cyc++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      #1;
      if (in_valid && in_ready) accepted++;
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("soak_accepted", 32'(accepted), 32'd2000);
    check("soak_queue_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
